pwm_multi_ch: RTL and testbench
===============================

Name: pwm_multi_ch

Overview:
Parametrised N-channel PWM engine. Replaces the fixed 3-channel, 8-bit, free-running-divider PWM path with:
- a programmable prescaler
- a programmable period
- edge-aligned or center-aligned counting
- per-channel shadow duty registers that load glitch-free at the period boundary

Sits between the controller (write port) and the board PWM pins. One clock domain.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CW, 8, counter/duty/period width in bits
PW, 8, prescaler width in bits
CHW, 4, channel-select width; must satisfy 2**CHW >= N_CH

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; 0 holds counter and prescaler at 0
presc  in  PW  tick every presc+1 clk cycles; sampled continuously
period  in  CW  counter top value; loaded at period boundary
mode  in  1  0 = edge-aligned, 1 = center-aligned; loaded at period boundary
wr_en  in  1  single-cycle duty write strobe
wr_ch  in  CHW  channel index for the write
wr_val  in  CW  duty value for the write
pwm  out  N_CH  PWM outputs, bit i = channel i
count  out  CW  current counter value
period_end  out  1  one-clk pulse at each period boundary
upd_done  out  1  one-clk pulse when pending shadows were applied
wr_err  out  1  one-clk pulse, write to wr_ch >= N_CH

Behaviour:
- Reset (async assert, sync release):
  - presc_cnt, count, dir, shadows, active duties and pending flags = 0
  - period_act = 0, mode_act = 0
  - pwm, period_end, upd_done, wr_err = 0
- Prescaler:
  - presc_cnt increments each clk.
  - tick asserts when presc_cnt == presc; presc_cnt then returns to 0.
  - presc = 0 gives a tick every clk.
  - If presc is lowered below presc_cnt, presc_cnt wraps through its full range (no early tick).
- en = 0:
  - presc_cnt, count and dir are forced to 0.
  - pwm forced 0 next clk.
  - Shadow writes are still accepted; no boundary occurs.
- Edge mode, on each tick:
  - count == period_act: count <= 0 (boundary).
  - otherwise: count <= count + 1.
- Center mode, on each tick:
  - dir = up: count + 1; at period_act, dir <= down and count <= period_act - 1.
  - dir = down: count - 1; at 0, dir <= up, count <= 1, and this is the boundary.
  - period_act = 0 in center mode: count stays 0 and every tick is a boundary.
- Boundary tick (either mode):
  - period_act <= period and mode_act <= mode.
  - Every channel with pending = 1 copies its shadow to active and clears pending.
  - period_end = 1 the next clk.
  - upd_done = 1 the next clk if any channel was pending.
  - On a mode change, count and dir restart at 0/up.
- Compare:
  - pwm[i] <= en & (count < duty_act[i]), registered, so one clk latency after count.
  - duty_act = 0: constant low.
  - duty_act > period_act (edge mode) or >= period_act (center mode): constant high.
- Writes:
  - wr_en with wr_ch < N_CH: shadow[wr_ch] <= wr_val, pending <= 1.
  - Back-to-back writes to the same channel: the last one wins.
  - wr_ch >= N_CH: no state change; wr_err pulses the next clk.
- Write in the same clk as a boundary:
  - The boundary copies the pre-write shadow.
  - The new value remains pending until the next boundary.
- Reset mid-period: all of the above return to reset values immediately; pending writes are lost.

Optional Feature:
Macro PWM_FAULT_EN.
- Defined:
  - Adds input fault (1 bit) and output fault_st (1 bit).
  - fault = 1 sets fault_st the next clk.
  - While fault_st = 1, pwm is forced to all-zero; counter keeps running.
  - fault_st clears only at the first period boundary with fault = 0.
  - Reset clears fault_st.
- Not defined: the ports are absent and there is no forcing logic.

Test Plan:
1. N_CH=4, presc=0, period=9, edge; write ch0=3, ch1=0, ch2=10, ch3=5 -> from the second boundary: ch0 high 3 of 10 ticks, ch1 always low, ch2 always high, ch3 high 5/10; period_end every 10 clk.
2. presc=3, period=4, center; write ch0=2 -> count 0,1,2,3,4,3,2,1,0 with each value held 4 clk; ch0 high while count < 2; period_end every 32 clk.
3. Write ch1=7 mid-period, then ch1=2 before the boundary -> pwm[1] duty unchanged until the boundary, then uses 2; upd_done exactly once.
4. wr_en in the same clk as the boundary (ch0=6) -> no change that period; applied at the following boundary with upd_done.
5. wr_ch=7 with N_CH=4 -> wr_err one clk, all duties unchanged; toggle en=0 mid-period -> count=0, pwm=0 next clk.
6. Assert rst mid-period with pending writes -> all outputs 0 immediately; after release the pending value is not applied. With PWM_FAULT_EN: fault pulse -> pwm=0 until the first boundary after fault drops.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM engine with programmable prescaler and period,
// edge- or center-aligned counting, and per-channel shadow duty registers
// that transfer to the active compare registers only at a period boundary.
//
// Optional build macro: PWM_FAULT_EN adds a fault input and fault_st status.
// While fault_st is set all PWM outputs are forced low; it clears at the
// first period boundary seen with fault deasserted.
//
// Handshake: the write port has no backpressure. A write is a single-clk
// wr_en strobe with wr_ch/wr_val valid in the same clk; it is always taken.
// An out-of-range channel produces a one-clk wr_err pulse and is dropped.
module pwm_multi_ch #(
    parameter int N_CH = 4,
    parameter int CW   = 8,
    parameter int PW   = 8,
    parameter int CHW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PW-1:0]   presc,
    input  logic [CW-1:0]   period,
    input  logic            mode,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [CW-1:0]   wr_val,
`ifdef PWM_FAULT_EN
    input  logic            fault,
    output logic            fault_st,
`endif
    output logic [N_CH-1:0] pwm,
    output logic [CW-1:0]   count,
    output logic            period_end,
    output logic            upd_done,
    output logic            wr_err
);

    localparam logic [CHW:0] N_CH_W = (CHW+1)'(N_CH);

    logic [PW-1:0]   presc_cnt;
    logic            tick;
    logic            dir;          // 0 = counting up, 1 = counting down
    logic [CW-1:0]   period_act;
    logic            mode_act;
    logic [CW-1:0]   count_next;
    logic            dir_next;
    logic            boundary;
    logic            wr_ok;
    logic [N_CH-1:0] wr_hit;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pwm_q;
    logic [N_CH-1:0] pwm_next;
    logic [CW-1:0]   shadow   [N_CH];
    logic [CW-1:0]   duty_act [N_CH];

    // Prescaler tick; lowering presc below presc_cnt lets the counter wrap.
    assign tick = en && (presc_cnt == presc);

    // Next counter value, direction and period-boundary detection.
    always_comb begin
        count_next = count;
        dir_next   = dir;
        boundary   = 1'b0;
        if (tick) begin
            if (!mode_act) begin
                if (count == period_act) begin
                    count_next = '0;
                    boundary   = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end else if (period_act == '0) begin
                count_next = '0;
                dir_next   = 1'b0;
                boundary   = 1'b1;
            end else if (!dir) begin
                if (count == period_act) begin
                    dir_next   = 1'b1;
                    count_next = period_act - 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    dir_next   = 1'b0;
                    count_next = CW'(1);
                    boundary   = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            // A mode change restarts the new waveform from its origin.
            if (boundary && (mode != mode_act)) begin
                count_next = '0;
                dir_next   = 1'b0;
            end
        end
    end

    // Prescaler, counter and the period/mode registers loaded at boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt  <= '0;
            count      <= '0;
            dir        <= 1'b0;
            period_act <= '0;
            mode_act   <= 1'b0;
            period_end <= 1'b0;
        end else begin
            period_end <= boundary;
            if (!en) begin
                presc_cnt <= '0;
                count     <= '0;
                dir       <= 1'b0;
            end else begin
                presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                count     <= count_next;
                dir       <= dir_next;
                if (boundary) begin
                    period_act <= period;
                    mode_act   <= mode;
                end
            end
        end
    end

    // Decode the write strobe into per-channel hits.
    always_comb begin
        wr_ok = ({1'b0, wr_ch} < N_CH_W);
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_en && wr_ok && (wr_ch == CHW'(i));
        end
    end

    // Shadow writes and boundary transfer; a same-clk write stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i]   <= '0;
                duty_act[i] <= '0;
            end
            pending  <= '0;
            upd_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_hit[i]) shadow[i] <= wr_val;
                if (boundary && pending[i]) duty_act[i] <= shadow[i];
            end
            pending  <= wr_hit | (pending & {N_CH{~boundary}});
            upd_done <= boundary && (|pending);
            wr_err   <= wr_en && !wr_ok;
        end
    end

    // Compare; center mode treats duty >= period as full-on.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pwm_next[i] = en && (duty_act[i] != '0) &&
                          ((count < duty_act[i]) ||
                           (mode_act && (duty_act[i] >= period_act)));
        end
    end

    // Registered PWM outputs, one clk behind count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_next;
    end

`ifdef PWM_FAULT_EN
    // Fault latch: set by fault, released at a boundary with fault low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           fault_st <= 1'b0;
        else if (fault)    fault_st <= 1'b1;
        else if (boundary) fault_st <= 1'b0;
    end

    assign pwm = pwm_q & {N_CH{~fault_st}};
`else
    assign pwm = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed bench for pwm_multi_ch (N_CH=4, CW=8, PW=8, CHW=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_pwm_multi_ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] presc = '0;
    logic [7:0] period = '0;
    logic       mode = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = '0;
    logic [7:0] wr_val = '0;
    logic       fault = 1'b0;
    logic       fault_st;
    logic [3:0] pwm;
    logic [7:0] count;
    logic       period_end;
    logic       upd_done;
    logic       wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_ch #(.N_CH(4), .CW(8), .PW(8), .CHW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .presc      (presc),
        .period     (period),
        .mode       (mode),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_val     (wr_val),
`ifdef PWM_FAULT_EN
        .fault      (fault),
        .fault_st   (fault_st),
`endif
        .pwm        (pwm),
        .count      (count),
        .period_end (period_end),
        .upd_done   (upd_done),
        .wr_err     (wr_err)
    );

`ifndef PWM_FAULT_EN
    assign fault_st = 1'b0;
`endif

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step falling edges until period_end is seen or the budget runs out.
    task automatic wait_pe(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (period_end) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm, count} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_pwm_count: got %h expected 000", {pwm, count});
        end
        n_checks++;
        if ({period_end, upd_done, wr_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 000", {period_end, upd_done, wr_err});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_count: got %0d expected 0", count);
        end
    endtask

    // Edge mode, period 9, four duties covering low/partial/full cases.
    task automatic test_edge;
        bit ok;
        int hi [4];
        logic [7:0] duties [4];
        duties = '{8'd3, 8'd0, 8'd10, 8'd5};
        en = 1'b1; presc = 8'd0; period = 8'd9; mode = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1; wr_ch = 4'(c); wr_val = duties[c];
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_pe(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_boundary_timeout: got %b expected 1", ok);
        end
        n_checks++;
        if ({count, upd_done} !== {8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL edge_boundary_state: count %0d upd %b expected 0 1", count, upd_done);
        end
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm[c]);
            n_checks++;
            if (count !== ((j == 10) ? 8'd0 : 8'(j))) begin
                n_fail++;
                $display("FAIL edge_count_%0d: got %0d expected %0d", j, count, (j == 10) ? 0 : j);
            end
        end
        n_checks++;
        if (period_end !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_period_10: got %b expected 1", period_end);
        end
        n_checks++;
        if ({hi[0], hi[1], hi[2], hi[3]} !== {32'd3, 32'd0, 32'd10, 32'd5}) begin
            n_fail++;
            $display("FAIL edge_duty: got %0d %0d %0d %0d expected 3 0 10 5", hi[0], hi[1], hi[2], hi[3]);
        end
    endtask

    // Center mode, presc 3, period 4; first period after the switch has 9 ticks.
    task automatic test_center;
        bit ok;
        int n;
        int seq [9];
        logic [7:0] exp_cnt;
        seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
        presc = 8'd3; period = 8'd4; mode = 1'b1;
        wr_en = 1'b1; wr_ch = 4'd0; wr_val = 8'd2;
        @(negedge clk);
        wr_en = 1'b0;
        wait_pe(60, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL center_switch_timeout: got %b expected 1", ok);
        end
        n_checks++;
        if ({count, upd_done} !== {8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL center_switch_state: count %0d upd %b expected 0 1", count, upd_done);
        end
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            exp_cnt = (j < 36) ? 8'(seq[j/4]) : 8'd1;
            n_checks++;
            if (count !== exp_cnt) begin
                n_fail++;
                $display("FAIL center_count_%0d: got %0d expected %0d", j, count, exp_cnt);
            end
            n_checks++;
            if (pwm[0] !== (seq[(j-1)/4] < 2)) begin
                n_fail++;
                $display("FAIL center_pwm0_%0d: got %b expected %b", j, pwm[0], seq[(j-1)/4] < 2);
            end
        end
        n_checks++;
        if (period_end !== 1'b1) begin
            n_fail++;
            $display("FAIL center_first_boundary: got %b expected 1", period_end);
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (period_end) begin
                n = i;
                break;
            end
        end
        n_checks++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL center_period_len: got %0d expected 32", n);
        end
    endtask

    // Two writes to ch1 inside one period: only the last one lands.
    task automatic test_back_to_back;
        bit ok;
        int hi, upd;
        hi = 0; upd = 0; ok = 1'b0;
        wr_en = 1'b1; wr_ch = 4'd1; wr_val = 8'd7;
        @(negedge clk);
        wr_val = 8'd2;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            hi  += int'(pwm[1]);
            upd += int'(upd_done);
            if (period_end) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %b expected 1", ok);
        end
        n_checks++;
        if (hi !== 0) begin
            n_fail++;
            $display("FAIL b2b_pre_boundary_pwm1: got %0d high clks expected 0", hi);
        end
        hi = 0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            hi  += int'(pwm[1]);
            upd += int'(upd_done);
        end
        n_checks++;
        if (period_end !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_boundary: got %b expected 1", period_end);
        end
        n_checks++;
        if (hi !== 12) begin
            n_fail++;
            $display("FAIL b2b_duty_ch1: got %0d high clks expected 12", hi);
        end
        n_checks++;
        if (upd !== 1) begin
            n_fail++;
            $display("FAIL b2b_upd_count: got %0d expected 1", upd);
        end
    endtask

    // Write sampled in the boundary clk is deferred one full period.
    task automatic test_write_at_boundary;
        int hi;
        repeat (31) @(negedge clk);
        wr_en = 1'b1; wr_ch = 4'd0; wr_val = 8'd6;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if ({period_end, upd_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL wab_boundary: pe/upd got %b expected 10", {period_end, upd_done});
        end
        hi = 0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            hi += int'(pwm[0]);
        end
        n_checks++;
        if ({period_end, upd_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL wab_next_boundary: pe/upd got %b expected 11", {period_end, upd_done});
        end
        n_checks++;
        if (hi !== 12) begin
            n_fail++;
            $display("FAIL wab_old_duty: got %0d high clks expected 12", hi);
        end
        hi = 0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            hi += int'(pwm[0]);
        end
        n_checks++;
        if (hi !== 32) begin
            n_fail++;
            $display("FAIL wab_new_duty: got %0d high clks expected 32", hi);
        end
    endtask

    // Out-of-range write, then en dropped mid-period.
    task automatic test_err_en;
        bit ok;
        int pe_n;
        wr_en = 1'b1; wr_ch = 4'd7; wr_val = 8'd1;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_pulse: got %b expected 1", wr_err);
        end
        @(negedge clk);
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_width: got %b expected 0", wr_err);
        end
        wait_pe(40, ok);
        n_checks++;
        if ({ok, upd_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_err_no_update: ok/upd got %b expected 10", {ok, upd_done});
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (pwm[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_disable_pwm0: got %b expected 1", pwm[0]);
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({count, pwm} !== 12'h000) begin
            n_fail++;
            $display("FAIL disable_forced: count %0d pwm %b expected 0 0000", count, pwm);
        end
        pe_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pe_n += int'(period_end);
        end
        n_checks++;
        if (pe_n !== 0) begin
            n_fail++;
            $display("FAIL disable_no_boundary: got %0d expected 0", pe_n);
        end
    endtask

    // Reset mid-period discards a pending write.
    task automatic test_reset_mid;
        int upd, pwm_n, pe_n;
        en = 1'b1;
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_ch = 4'd1; wr_val = 8'd9;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm === 4'b0000) begin
            n_fail++;
            $display("FAIL pre_reset_pwm: got %b expected nonzero", pwm);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pwm, count, period_end, upd_done, wr_err, fault_st} !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: pwm %b count %0d pulses %b expected all 0", pwm, count,
                     {period_end, upd_done, wr_err, fault_st});
        end
        @(negedge clk);
        rst = 1'b0;
        upd = 0; pwm_n = 0; pe_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            upd   += int'(upd_done);
            pwm_n += int'(pwm != 4'b0000);
            pe_n  += int'(period_end);
        end
        n_checks++;
        if ({upd, pwm_n} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_lost_pending: upd %0d pwm_active %0d expected 0 0", upd, pwm_n);
        end
        n_checks++;
        if (pe_n < 1) begin
            n_fail++;
            $display("FAIL reset_restart: got %0d boundaries expected >=1", pe_n);
        end
    endtask

`ifdef PWM_FAULT_EN
    task automatic test_fault;
        bit ok;
        int pwm_n;
        wr_en = 1'b1; wr_ch = 4'd2; wr_val = 8'd10;
        @(negedge clk);
        wr_en = 1'b0;
        wait_pe(80, ok);
        wait_pe(80, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (pwm[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_pre_pwm2: got %b expected 1", pwm[2]);
        end
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        n_checks++;
        if ({fault_st, pwm} !== 5'b10000) begin
            n_fail++;
            $display("FAIL fault_set: fault_st %b pwm %b expected 1 0000", fault_st, pwm);
        end
        pwm_n = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_end) begin
                ok = 1'b1;
                break;
            end
            pwm_n += int'(pwm != 4'b0000);
        end
        n_checks++;
        if ({ok, pwm_n} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL fault_hold: ok %b pwm_active %0d expected 1 0", ok, pwm_n);
        end
        n_checks++;
        if ({fault_st, pwm[2]} !== 2'b01) begin
            n_fail++;
            $display("FAIL fault_release: fault_st %b pwm2 %b expected 0 1", fault_st, pwm[2]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_back_to_back();
        test_write_at_boundary();
        test_err_en();
        test_reset_mid();
`ifdef PWM_FAULT_EN
        test_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
